// File: rtl/count_sequencer.sv
// Run controller for the prescaled event counter: prescaler, start/pause/resume/terminal-count FSM.
// Optional feature: define COUNT_SEQ_AUTO_RELOAD_EN to keep running and pulse done periodically on terminal count.
module count_sequencer #(
    parameter int PRESCALE = 1000000,
    parameter int WIDTH    = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    input  logic [WIDTH-1:0] target,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             done,
    output logic             busy,
    output logic [1:0]       state
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             tick_q, tick_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] count_inc;

    assign count_inc = count_q + WIDTH'(1);

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        target_d = target_q;
        presc_d  = presc_q;
        tick_d   = 1'b0;
        done_d   = 1'b0;

        if (clear) begin
            state_d = IDLE;
            count_d = '0;
            presc_d = '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    presc_d = '0;
                    if (start) begin
                        target_d = target;
                        count_d  = '0;
                        // A zero target is already at terminal count.
                        if (target == '0) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = RUN;
                        end
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_d = PAUSE;
                    end
                    if (presc_q == PRESC_LAST) begin
                        presc_d = '0;
                        tick_d  = 1'b1;
                        count_d = count_inc;
                        if (count_inc == target_q) begin
                            done_d = 1'b1;
`ifdef COUNT_SEQ_AUTO_RELOAD_EN
                            count_d = '0;
                            state_d = RUN;
`else
                            // Terminal count overrides a coincident pause.
                            state_d = DONE;
`endif
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                PAUSE: begin
                    if (start) begin
                        state_d = RUN;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign busy_d = (state_d == RUN);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            target_q <= '0;
            presc_q  <= '0;
            tick_q   <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            target_q <= target_d;
            presc_q  <= presc_d;
            tick_q   <= tick_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign count = count_q;
    assign tick  = tick_q;
    assign done  = done_q;
    assign busy  = busy_q;
    assign state = state_q;

endmodule

// File: tb/tb_count_sequencer.sv
// Directed testbench for count_sequencer with PRESCALE=4, WIDTH=10.
module tb_count_sequencer;

    localparam int PRESCALE = 4;
    localparam int WIDTH    = 10;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             stop;
    logic             clear;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] count;
    logic             tick;
    logic             done;
    logic             busy;
    logic [1:0]       state;

    int total = 0;
    int bad   = 0;

    count_sequencer #(.PRESCALE(PRESCALE), .WIDTH(WIDTH)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .stop   (stop),
        .clear  (clear),
        .target (target),
        .count  (count),
        .tick   (tick),
        .done   (done),
        .busy   (busy),
        .state  (state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start  = 1'($urandom_range(0, 1));
            stop   = 1'($urandom_range(0, 1));
            clear  = 1'($urandom_range(0, 1));
            target = WIDTH'($urandom_range(0, 1023));
            step();
            total++;
            if ({count, state, tick, done, busy} !== '0) begin
                bad++;
                $display("FAIL reset cyc%0d: count=%0d state=%0d tick=%b done=%b busy=%b, want all 0",
                         i, count, state, tick, done, busy);
            end
        end
        reset = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        clear = 1'b0;
        step();
        total++;
        if (state !== 2'd0 || count !== '0) begin
            bad++;
            $display("FAIL post_reset_idle: state=%0d count=%0d, want 0 0", state, count);
        end
    endtask

    task automatic test_basic_run();
        target = 10'd3;
        pulse_start();
        total++;
        if (state !== 2'd1 || busy !== 1'b1 || count !== 10'd0) begin
            bad++;
            $display("FAIL basic_start: state=%0d busy=%b count=%0d, want 1 1 0", state, busy, count);
        end
        for (int k = 1; k <= 12; k++) begin
            step();
            total++;
            if (tick !== (k % 4 == 0) || count !== WIDTH'(k / 4) || done !== (k == 12)) begin
                bad++;
                $display("FAIL basic_cyc%0d: tick=%b count=%0d done=%b, want %b %0d %b",
                         k, tick, count, done, (k % 4 == 0), k / 4, (k == 12));
            end
        end
        total++;
        if (state !== 2'd3 || busy !== 1'b0) begin
            bad++;
            $display("FAIL basic_done_state: state=%0d busy=%b, want 3 0", state, busy);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            total++;
            if (count !== 10'd3 || done !== 1'b0 || tick !== 1'b0 || state !== 2'd3) begin
                bad++;
                $display("FAIL basic_hold%0d: count=%0d done=%b tick=%b state=%0d, want 3 0 0 3",
                         k, count, done, tick, state);
            end
        end
    endtask

    task automatic test_pause_resume();
        target = 10'd5;
        pulse_start();
        for (int k = 1; k <= 5; k++) step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        total++;
        if (state !== 2'd2 || count !== 10'd1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL pause_enter: state=%0d count=%0d busy=%b, want 2 1 0", state, count, busy);
        end
        target = 10'd1;
        for (int k = 0; k < 20; k++) begin
            step();
            total++;
            if (count !== 10'd1 || state !== 2'd2 || tick !== 1'b0) begin
                bad++;
                $display("FAIL pause_hold%0d: count=%0d state=%0d tick=%b, want 1 2 0", k, count, state, tick);
            end
        end
        pulse_start();
        total++;
        if (state !== 2'd1 || busy !== 1'b1 || count !== 10'd1) begin
            bad++;
            $display("FAIL resume: state=%0d busy=%b count=%0d, want 1 1 1", state, busy, count);
        end
        for (int k = 1; k <= 14; k++) begin
            step();
            total++;
            if (tick !== ((k + 2) % 4 == 0) || count !== WIDTH'(1 + (k + 2) / 4) || done !== (k == 14)) begin
                bad++;
                $display("FAIL resume_cyc%0d: tick=%b count=%0d done=%b, want %b %0d %b",
                         k, tick, count, done, ((k + 2) % 4 == 0), 1 + (k + 2) / 4, (k == 14));
            end
        end
        total++;
        if (state !== 2'd3) begin
            bad++;
            $display("FAIL resume_done_state: state=%0d, want 3", state);
        end
    endtask

    task automatic test_clear_priority();
        target = 10'd5;
        pulse_start();
        for (int k = 1; k <= 11; k++) step();
        total++;
        if (count !== 10'd2 || state !== 2'd1) begin
            bad++;
            $display("FAIL clear_setup: count=%0d state=%0d, want 2 1", count, state);
        end
        clear = 1'b1;
        stop  = 1'b1;
        start = 1'b1;
        step();
        clear = 1'b0;
        stop  = 1'b0;
        start = 1'b0;
        total++;
        if (state !== 2'd0 || count !== 10'd0 || tick !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL clear_all_cmds: state=%0d count=%0d tick=%b done=%b busy=%b, want 0 0 0 0 0",
                     state, count, tick, done, busy);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        total++;
        if (state !== 2'd0 || count !== 10'd0) begin
            bad++;
            $display("FAIL clear_idle_stop: state=%0d count=%0d, want 0 0", state, count);
        end
    endtask

    task automatic test_stop_on_tick();
        target = 10'd2;
        pulse_start();
        for (int k = 1; k <= 3; k++) step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        total++;
        if (state !== 2'd2 || count !== 10'd1 || tick !== 1'b1) begin
            bad++;
            $display("FAIL stop_on_tick: state=%0d count=%0d tick=%b, want 2 1 1", state, count, tick);
        end
        pulse_start();
        for (int k = 1; k <= 3; k++) step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        total++;
        if (state !== 2'd3 || count !== 10'd2 || done !== 1'b1) begin
            bad++;
            $display("FAIL stop_on_terminal: state=%0d count=%0d done=%b, want 3 2 1", state, count, done);
        end
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic test_target_zero();
        target = 10'd0;
        pulse_start();
        total++;
        if (state !== 2'd3 || done !== 1'b1 || count !== 10'd0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL zero_start: state=%0d done=%b count=%0d busy=%b, want 3 1 0 0",
                     state, done, count, busy);
        end
        step();
        total++;
        if (state !== 2'd3 || done !== 1'b0) begin
            bad++;
            $display("FAIL zero_after: state=%0d done=%b, want 3 0", state, done);
        end
        target = 10'd2;
        pulse_start();
        total++;
        if (state !== 2'd1 || count !== 10'd0) begin
            bad++;
            $display("FAIL restart: state=%0d count=%0d, want 1 0", state, count);
        end
        for (int k = 1; k <= 8; k++) begin
            step();
            total++;
            if (count !== WIDTH'(k / 4) || done !== (k == 8)) begin
                bad++;
                $display("FAIL restart_cyc%0d: count=%0d done=%b, want %0d %b", k, count, done, k / 4, (k == 8));
            end
        end
        total++;
        if (state !== 2'd3) begin
            bad++;
            $display("FAIL restart_done_state: state=%0d, want 3", state);
        end
    endtask

    task automatic test_auto_reload();
        target = 10'd2;
        pulse_start();
        for (int k = 1; k <= 24; k++) begin
            step();
            total++;
            if (tick !== (k % 4 == 0) || count !== WIDTH'((k / 4) % 2) || done !== (k % 8 == 0) || busy !== 1'b1) begin
                bad++;
                $display("FAIL reload_cyc%0d: tick=%b count=%0d done=%b busy=%b, want %b %0d %b 1",
                         k, tick, count, done, busy, (k % 4 == 0), (k / 4) % 2, (k % 8 == 0));
            end
        end
        clear = 1'b1;
        step();
        clear = 1'b0;
        total++;
        if (busy !== 1'b0 || state !== 2'd0 || count !== 10'd0) begin
            bad++;
            $display("FAIL reload_clear: busy=%b state=%0d count=%0d, want 0 0 0", busy, state, count);
        end
        target = 10'd0;
        pulse_start();
        total++;
        if (state !== 2'd3 || done !== 1'b1) begin
            bad++;
            $display("FAIL reload_zero: state=%0d done=%b, want 3 1", state, done);
        end
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        stop   = 1'b0;
        clear  = 1'b0;
        target = '0;
        test_reset();
`ifdef COUNT_SEQ_AUTO_RELOAD_EN
        test_auto_reload();
`else
        test_basic_run();
        test_pause_resume();
        test_clear_priority();
        test_stop_on_tick();
        test_target_zero();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
